// File: rtl/id_stage_module.sv
// rtl/id_stage_module.sv - ARM decode stage: decode, condition check, register file and ID/EX register
// Optional feature: define ID_WB_BYPASS_EN for same-cycle write-through from write-back to the read ports.
module id_stage_module (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [3:0]  status_in,
  input  logic        hazard_in,
  input  logic        flush_in,
  input  logic        wb_en_in,
  input  logic [3:0]  wb_dest_in,
  input  logic [31:0] wb_value_in,
  output logic        two_src,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic [31:0] pc_out,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b,
  output logic        s,
  output logic [3:0]  exe_cmd,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out
);

  logic [3:0]  cond;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic        i_bit;
  logic        s_bit;
  logic        flag_n, flag_z, flag_c, flag_v;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign {flag_n, flag_z, flag_c, flag_v} = status_in;

  logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic [3:0] dec_cmd;

  always_comb begin
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_cmd = 4'b0000;
    case (mode)
      2'b00: begin
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (opcode)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end
          4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; end
        endcase
      end
      2'b01: begin
        dec_cmd = 4'b0010;
        if (s_bit) begin
          dec_mr = 1'b1;
          dec_wb = 1'b1;
          dec_s  = 1'b1;
        end else begin
          dec_mw = 1'b1;
        end
      end
      2'b10: dec_b = 1'b1;
      default: ;
    endcase
  end

  logic cond_ok;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Source selection uses the raw decode so forwarding sees STR's Rd even when the condition fails.
  assign two_src = ((mode == 2'b00) && !i_bit) || dec_mw;
  assign src1    = instruction_in[19:16];
  assign src2    = dec_mw ? instruction_in[15:12] : instruction_in[3:0];

  logic [31:0] regs [16];
  logic [31:0] rd1, rd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en_in) begin
      regs[wb_dest_in] <= wb_value_in;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rd1 = (wb_en_in && (wb_dest_in == src1)) ? wb_value_in : regs[src1];
  assign rd2 = (wb_en_in && (wb_dest_in == src2)) ? wb_value_in : regs[src2];
`else
  assign rd1 = regs[src1];
  assign rd2 = regs[src2];
`endif

  logic kill;
  assign kill = hazard_in | ~cond_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_in) begin
      pc_out        <= '0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      exe_cmd       <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      src1_out      <= '0;
      src2_out      <= '0;
    end else begin
      pc_out        <= pc_in;
      wb_en         <= dec_wb & ~kill;
      mem_r_en      <= dec_mr & ~kill;
      mem_w_en      <= dec_mw & ~kill;
      b             <= dec_b & ~kill;
      s             <= dec_s & ~kill;
      exe_cmd       <= kill ? 4'b0000 : dec_cmd;
      val_rn        <= rd1;
      val_rm        <= rd2;
      imm           <= i_bit;
      shift_operand <= instruction_in[11:0];
      signed_imm_24 <= instruction_in[23:0];
      dest          <= instruction_in[15:12];
      src1_out      <= src1;
      src2_out      <= src2;
    end
  end

endmodule

// File: tb/tb_id_stage_module.sv
// tb/tb_id_stage_module.sv - scoreboard testbench for id_stage_module
module tb_id_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic [3:0]  status_in;
  logic        hazard_in;
  logic        flush_in;
  logic        wb_en_in;
  logic [3:0]  wb_dest_in;
  logic [31:0] wb_value_in;
  logic        two_src;
  logic [3:0]  src1, src2;
  logic [31:0] pc_out;
  logic        wb_en, mem_r_en, mem_w_en, b, s;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn, val_rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest, src1_out, src2_out;

  id_stage_module dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .status_in(status_in), .hazard_in(hazard_in), .flush_in(flush_in),
    .wb_en_in(wb_en_in), .wb_dest_in(wb_dest_in), .wb_value_in(wb_value_in),
    .two_src(two_src), .src1(src1), .src2(src2), .pc_out(pc_out),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
    .src1_out(src1_out), .src2_out(src2_out)
  );

  always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Expected control word: {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}
  localparam logic [8:0] C_NONE = 9'b0;
  localparam logic [8:0] C_ADD  = {5'b10000, 4'b0010};
  localparam logic [8:0] C_MOV  = {5'b10000, 4'b0001};
  localparam logic [8:0] C_MVN  = {5'b10000, 4'b1001};
  localparam logic [8:0] C_CMPS = {5'b00001, 4'b0100};
  localparam logic [8:0] C_STR  = {5'b00100, 4'b0010};
  localparam logic [8:0] C_LDR  = {5'b11001, 4'b0010};
  localparam logic [8:0] C_B    = {5'b00010, 4'b0000};

  typedef struct {
    logic [31:0] pc;
    logic [8:0]  ctl;
    logic [31:0] vrn, vrm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest, s1, s2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [16];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc_n = 32'h0000_0100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [3:0] idx, input logic we,
                                           input logic [3:0] wd, input logic [31:0] wv);
    if (BYPASS && we && (wd == idx)) return wv;
    return mdl[idx];
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("pc_out", pc_out, e.pc);
    check("ctl", {23'b0, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}, {23'b0, e.ctl});
    check("val_rn", val_rn, e.vrn);
    check("val_rm", val_rm, e.vrm);
    check("imm", {31'b0, imm}, {31'b0, e.imm});
    check("shift_operand", {20'b0, shift_operand}, {20'b0, e.shop});
    check("signed_imm_24", {8'b0, signed_imm_24}, {8'b0, e.simm});
    check("dest", {28'b0, dest}, {28'b0, e.dest});
    check("src1_out", {28'b0, src1_out}, {28'b0, e.s1});
    check("src2_out", {28'b0, src2_out}, {28'b0, e.s2});
  endtask

  task automatic cycle(input logic [31:0] instr, input logic [3:0] st, input logic hz,
                       input logic fl, input logic we, input logic [3:0] wd,
                       input logic [31:0] wv, input logic [8:0] ctl, input logic ts,
                       input logic [3:0] s2);
    exp_t e;
    @(negedge clk);
    pc_n           = pc_n + 32'd4;
    pc_in          = pc_n;
    instruction_in = instr;
    status_in      = st;
    hazard_in      = hz;
    flush_in       = fl;
    wb_en_in       = we;
    wb_dest_in     = wd;
    wb_value_in    = wv;
    #1;
    check("two_src", {31'b0, two_src}, {31'b0, ts});
    check("src1", {28'b0, src1}, {28'b0, instr[19:16]});
    check("src2", {28'b0, src2}, {28'b0, s2});
    if (fl) begin
      e = '{pc: 0, ctl: 0, vrn: 0, vrm: 0, imm: 0, shop: 0, simm: 0, dest: 0, s1: 0, s2: 0};
    end else begin
      e.pc   = pc_n;
      e.ctl  = ctl;
      e.vrn  = rd_model(instr[19:16], we, wd, wv);
      e.vrm  = rd_model(s2, we, wd, wv);
      e.imm  = instr[25];
      e.shop = instr[11:0];
      e.simm = instr[23:0];
      e.dest = instr[15:12];
      e.s1   = instr[19:16];
      e.s2   = s2;
    end
    sb.push_back(e);
    @(posedge clk);
    if (we) mdl[wd] = wv;
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, pc_out, 32'd0);
    check({tag, "_ctl"}, {23'b0, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}, 32'd0);
    check({tag, "_vals"}, val_rn | val_rm, 32'd0);
    check({tag, "_fields"}, {7'b0, imm, shift_operand, dest, src1_out, src2_out},
          32'd0);
    check({tag, "_simm"}, {8'b0, signed_imm_24}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    rst = 1'b1;
    pc_in = '0; instruction_in = '0; status_in = '0; hazard_in = 1'b0;
    flush_in = 1'b0; wb_en_in = 1'b0; wb_dest_in = '0; wb_value_in = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ADD R0,R5,R5: reads of R5 after reset return 0
    cycle(32'hE085_0005, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd5);
    // write R1 = 7 alongside a never-condition instruction
    cycle(32'hF000_0000, 4'h0, 0, 0, 1, 4'd1, 32'h7, C_NONE, 1, 4'd0);
    cycle(32'hE081_2001, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);
    // ADDEQ with Z clear, then set
    cycle(32'h0081_2001, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_NONE, 1, 4'd1);
    cycle(32'h0081_2001, 4'h4, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);
    // ADDGT passes with N=V, Z=0; ADDLT passes with N!=V and fails with N=V
    cycle(32'hC081_2001, 4'hB, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);
    cycle(32'hB081_2001, 4'h8, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);
    cycle(32'hB081_2001, 4'h9, 0, 0, 0, 4'd0, 32'h0, C_NONE, 1, 4'd1);
    // write R3, then STR R3,[R1] and LDR R3,[R1]
    cycle(32'hF000_0000, 4'h0, 0, 0, 1, 4'd3, 32'h1234_5678, C_NONE, 1, 4'd0);
    cycle(32'hE581_3000, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_STR, 1, 4'd3);
    cycle(32'hE591_3000, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_LDR, 0, 4'd0);
    // hazard, flush, both
    cycle(32'hE081_2001, 4'h0, 1, 0, 0, 4'd0, 32'h0, C_NONE, 1, 4'd1);
    cycle(32'hE081_2001, 4'h0, 0, 1, 0, 4'd0, 32'h0, C_NONE, 1, 4'd1);
    cycle(32'hE081_2001, 4'h0, 1, 1, 0, 4'd0, 32'h0, C_NONE, 1, 4'd1);
    // MOV R0,R4 while R4 is written in the same cycle, then again afterwards
    cycle(32'hE1A0_0004, 4'h0, 0, 0, 1, 4'd4, 32'hDEAD_BEEF, C_MOV, 1, 4'd4);
    cycle(32'hE1A0_0004, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_MOV, 1, 4'd4);
    // MVN immediate, CMPS, branch, mode 11, unlisted opcode
    cycle(32'hE3E0_00FF, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_MVN, 0, 4'hF);
    cycle(32'hE151_0002, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_CMPS, 1, 4'd2);
    cycle(32'hEA00_0010, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_B, 0, 4'd0);
    cycle(32'hEC00_0000, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_NONE, 0, 4'd0);
    cycle(32'hE060_0000, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_NONE, 1, 4'd0);
    cycle(32'hE081_2001, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);

    // asynchronous reset mid-operation clears outputs and the register file
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    cycle(32'hE081_2001, 4'h0, 0, 0, 0, 4'd0, 32'h0, C_ADD, 1, 4'd1);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_module.md
# id_stage_module

Decode stage of the 5-stage ARM pipeline, directly downstream of the instruction-fetch stage. It takes the registered `pc`/`instruction` from the IF/ID register, decodes the instruction, checks its condition field against the status flags, reads two operands from a 16×32 register file that write-back also writes, and captures everything in an ID/EX pipeline register. Hazard bubbles and branch flushes are applied at this register.

## Interface
Parameters: none.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset; asynchronous, active-high
- `pc_in`  input  32  PC+4 of instruction, from IF/ID
- `instruction_in`  input  32  fetched instruction, from IF/ID
- `status_in`  input  4  {N,Z,C,V} from status register
- `hazard_in`  input  1  insert bubble this cycle
- `flush_in`  input  1  branch taken; squash ID/EX contents
- `wb_en_in`  input  1  write-back enable
- `wb_dest_in`  input  4  write-back register index
- `wb_value_in`  input  32  write-back data
- `two_src`  output  1  comb.; instruction reads Rm, or is STR
- `src1`  output  4  comb.; Rn field [19:16]
- `src2`  output  4  comb.; Rm [3:0] normally, Rd [15:12] for STR
- `pc_out`  output  32  registered
- `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s`  output  1 each  registered control
- `exe_cmd`  output  4  registered ALU command
- `val_rn`, `val_rm`  output  32 each  registered operand values
- `imm`  output  1  registered I bit [25]
- `shift_operand`  output  12  registered [11:0]
- `signed_imm_24`  output  24  registered [23:0]
- `dest`  output  4  registered Rd [15:12]
- `src1_out`, `src2_out`  output  4 each  registered source indices, for forwarding

## Operation
- Mode [27:26]: 00 data-processing, 01 memory, 10 branch; 11 decodes as NOP (all controls 0).
- Data-processing opcode [24:21] → `exe_cmd`: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110. Other opcodes → NOP. `wb_en` = 1 except CMP/TST. `s` = bit [20].
- Memory: `exe_cmd` = 0010; LDR (S=1): `mem_r_en`, `wb_en`, `s` = 1; STR (S=0): `mem_w_en` = 1.
- Branch: `b` = 1, all other controls 0.
- Condition [31:28]: standard ARM EQ..AL over {N,Z,C,V}; 1111 is treated as never. A failed condition zeroes `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s`, `exe_cmd`.
- `hazard_in` = 1 zeroes the same controls (bubble). Data fields still load.
- `two_src` = 1 when (mode 00 and I = 0) or `mem_w_en` is decoded.
- Register file: 16×32, reset to zero. It is written on rising `clk` when `wb_en_in` is high. Reads are combinational.

## Timing
- Decode, register read and hazard outputs are combinational within a cycle. The ID/EX register adds 1 cycle of latency.
- Reset (asynchronous): all registered outputs 0; all register-file entries 0.
- `flush_in` = 1 at a clock edge: ID/EX loads all-zero, regardless of `hazard_in`.
- `hazard_in` and `flush_in` are both 1: flush wins.
- Write and read of the same index in the same cycle: see Configuration.
- `rst` asserted mid-operation clears everything immediately. No clock edge is needed.

## Configuration
- `ID_WB_BYPASS_EN` defined: when `wb_en_in` is high and `wb_dest_in` equals `src1` or `src2`, the corresponding read returns `wb_value_in` in the same cycle (write-through).
- Not defined: the read returns the old stored value. The new value is visible from the following cycle.

## Test plan
- Reset: assert `rst` asynchronously → all outputs 0, and a read of R5 = 0.
- Write-back: write R1 = 0x0000_0007, then decode `ADD R2,R1,R1` (0xE081_2001) → next cycle `exe_cmd` = 0010, `val_rn` = `val_rm` = 7, `dest` = 2, `wb_en` = 1, `two_src` = 1.
- Condition: `ADDEQ` (0x0081_2001) with status Z = 0 → all controls 0. With Z = 1 → `wb_en` = 1.
- STR R3,[R1] (0xE581_3000) → `mem_w_en` = 1, `src2` = 3, `two_src` = 1. LDR (0xE591_3000) → `mem_r_en` = 1, `wb_en` = 1.
- Hazard and flush: `hazard_in` = 1 on ADD → controls 0 but `dest` = 2. `flush_in` = 1 → `pc_out` = 0 and `dest` = 0. Both asserted together → all outputs 0.
- Bypass: write R4 = 0xDEAD_BEEF in the same cycle as decoding `MOV R0,R4` → `val_rm` = 0xDEAD_BEEF with `ID_WB_BYPASS_EN`, and the old value without it.
